// File: rtl/dac_serial_tx.sv
// dac_serial_tx
//
// Serial transmitter for a 12-bit SPI-style DAC (DAC121S101 class,
// SYNC/SCLK/DIN with a 16-bit frame). A parallel sample is accepted on a
// start strobe. It is shifted out MSB-first as {2'b00, pd, din'}, and
// completion is reported with a one-cycle done_tick.
//
// Optional build macro: DAC_OFFSET_BINARY_EN
//   defined   : din is two's complement. It is sent as offset binary
//               (MSB inverted).
//   undefined : din is sent unchanged (straight binary).
//
// Parameters
//   DATA_W   sample width (frame is DATA_W+4 bits)
//   CLK_DIV  clk cycles per SCLK half-period (>= 1)
//   CS_HOLD  clk cycles cs_n stays high after a frame before done (>= 1)
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-low reset
//   start      transmit request, sampled only while idle
//   din        sample to send
//   pd         DAC power-down mode bits (00 = normal)
//   sclk       serial clock to the DAC, idles high
//   cs_n       frame select (SYNC), active low
//   sdata      serial data, MSB first
//   busy       high from accept until done_tick
//   done_tick  one-cycle pulse at the end of a frame

module dac_serial_tx #(
    parameter int DATA_W  = 12,
    parameter int CLK_DIV = 4,
    parameter int CS_HOLD = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic [1:0]        pd,
    output logic              sclk,
    output logic              cs_n,
    output logic              sdata,
    output logic              busy,
    output logic              done_tick
);

    localparam int FRAME_W = DATA_W + 4;
    localparam int EDGES   = 2 * FRAME_W;
    localparam int DIV_W   = $clog2(CLK_DIV) + 1;
    localparam int HALF_W  = $clog2(EDGES) + 1;
    localparam int HOLD_W  = $clog2(CS_HOLD) + 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(EDGES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t              state, state_next;
    logic [FRAME_W-1:0]  shreg, shreg_next;
    logic [DIV_W-1:0]    div_cnt, div_next;
    logic [HALF_W-1:0]   half_cnt, half_next;
    logic [HOLD_W-1:0]   hold_cnt, hold_next;
    logic                sclk_next;
    logic                cs_n_next;
    logic                busy_next;
    logic                done_next;
    logic [DATA_W-1:0]   din_conv;

`ifdef DAC_OFFSET_BINARY_EN
    // Two's complement to offset binary: flipping the sign bit maps the most
    // negative code to 0x000 and zero to mid-scale.
    assign din_conv = {~din[DATA_W-1], din[DATA_W-2:0]};
`else
    assign din_conv = din;
`endif

    // The frame MSB is always presented on sdata. Clearing the shift register
    // at the end of a frame, or on reset, parks sdata at 0.
    assign sdata = shreg[FRAME_W-1];

    // State and output registers. Every output is a flop, so there is no
    // combinational path from the inputs to the DAC pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shreg     <= '0;
            div_cnt   <= '0;
            half_cnt  <= '0;
            hold_cnt  <= '0;
            sclk      <= 1'b1;
            cs_n      <= 1'b1;
            busy      <= 1'b0;
            done_tick <= 1'b0;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            div_cnt   <= div_next;
            half_cnt  <= half_next;
            hold_cnt  <= hold_next;
            sclk      <= sclk_next;
            cs_n      <= cs_n_next;
            busy      <= busy_next;
            done_tick <= done_next;
        end
    end

    // Next-state logic. half_cnt counts SCLK edges already produced in the
    // frame, so the edge about to happen is number half_cnt+1. Odd edges fall
    // and the DAC samples on them. Even edges rise and advance the data. The
    // last even edge closes the frame together with cs_n.
    always_comb begin
        state_next = state;
        shreg_next = shreg;
        div_next   = div_cnt;
        half_next  = half_cnt;
        hold_next  = hold_cnt;
        sclk_next  = sclk;
        cs_n_next  = cs_n;
        busy_next  = busy;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    shreg_next = {2'b00, pd, din_conv};
                    cs_n_next  = 1'b0;
                    sclk_next  = 1'b1;
                    busy_next  = 1'b1;
                    div_next   = '0;
                    half_next  = '0;
                    state_next = SHIFT;
                end
            end

            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_next = '0;
                    if (!half_cnt[0]) begin
                        sclk_next = 1'b0;
                        half_next = half_cnt + 1'b1;
                    end else if (half_cnt == HALF_LAST) begin
                        sclk_next  = 1'b1;
                        cs_n_next  = 1'b1;
                        shreg_next = '0;
                        half_next  = '0;
                        hold_next  = '0;
                        state_next = HOLD;
                    end else begin
                        sclk_next  = 1'b1;
                        shreg_next = {shreg[FRAME_W-2:0], 1'b0};
                        half_next  = half_cnt + 1'b1;
                    end
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end

            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    hold_next  = '0;
                    state_next = IDLE;
                end else begin
                    hold_next = hold_cnt + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
